// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of rows swept for an n-input function.
  function automatic int n_rows(input int n_in);
    return 32'sd1 << n_in;
  endfunction

  // One extra bit so a fully mismatching table does not wrap.
  function automatic int err_width(input int n_in);
    return n_in + 32'sd1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle.sv
// Loadable down-counter that times how long each input vector is held.
module tt_settle_timer #(
  parameter int SETTLE = 1,
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] ONE    = CW'(32'd1);

  logic [CW-1:0] count_r;

  // Reload on request, otherwise count down to zero and stick there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= RELOAD;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input vectors of a combinational FUT, records its truth table
// and compares it against a latched expected table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  localparam int N_ROWS = n_rows(N_IN),
  localparam int ERR_W  = err_width(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_ROWS-1:0] expected,
  output logic [N_IN-1:0]   vec,
  input  logic              s,
  output logic              busy,
  output logic              done,
  output logic [N_ROWS-1:0] table_out,
  output logic              match,
  output logic [ERR_W-1:0]  err_count,
  output logic [N_IN-1:0]   first_err_idx
);

  localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(N_ROWS - 1);
  localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(32'd1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(32'd1);

  state_t              state_r, state_s;
  logic [N_ROWS-1:0]   exp_r, exp_s;
  logic [N_IN-1:0]     vec_s;
  logic                busy_s, done_s, match_s;
  logic [N_ROWS-1:0]   table_s;
  logic [ERR_W-1:0]    err_s;
  logic [N_IN-1:0]     first_s;
  logic                mismatch_s;
  logic                load_s, en_s, zero_s;

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .en    (en_s),
    .zero  (zero_s)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      exp_r         <= '0;
      vec           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      table_out     <= '0;
      match         <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      state_r       <= state_s;
      exp_r         <= exp_s;
      vec           <= vec_s;
      busy          <= busy_s;
      done          <= done_s;
      table_out     <= table_s;
      match         <= match_s;
      err_count     <= err_s;
      first_err_idx <= first_s;
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s    = state_r;
    exp_s      = exp_r;
    vec_s      = vec;
    busy_s     = busy;
    done_s     = 1'b0;
    table_s    = table_out;
    match_s    = match;
    err_s      = err_count;
    first_s    = first_err_idx;
    mismatch_s = 1'b0;
    load_s     = 1'b0;
    en_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          exp_s   = expected;
          table_s = '0;
          err_s   = '0;
          first_s = '0;
          match_s = 1'b0;
          vec_s   = '0;
          busy_s  = 1'b1;
          load_s  = 1'b1;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        en_s = 1'b1;
        if (zero_s) begin
          table_s[vec] = s;
          mismatch_s   = (s != exp_r[vec]);
          if (mismatch_s) begin
            err_s = err_count + ERR_ONE;
            // Only the first mismatch of the sweep records its row.
            if (err_count == '0) begin
              first_s = vec;
            end else begin
              first_s = first_err_idx;
            end
          end else begin
            err_s = err_count;
          end
          if (vec == LAST_VEC) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            vec_s   = '0;
            match_s = (err_count == '0) && !mismatch_s;
          end else begin
            vec_s  = vec + VEC_ONE;
            load_s = 1'b1;
          end
        end else begin
          vec_s = vec;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential test harness stage that wraps a combinational boolean function under test (FUT), e.g. the 2-input f(x,y).
- Upstream side: drives every input vector of the FUT in ascending binary order.
- Downstream side: samples the FUT output for each vector, assembles the observed truth table as a minterm mask, and compares it against an expected mask.
- Reports a match flag, a mismatch count and the index of the first mismatch.

Parameters:
- N_IN, 2: number of FUT inputs; N_ROWS = 2**N_IN rows are swept. Legal range 1..6.
- SETTLE, 1: cycles each vector is held before its output is sampled. Must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- expected  in  N_ROWS  expected truth table; bit i is the expected output for vector i. Latched at start.
- vec  out  N_IN  drive to the FUT inputs. vec[N_IN-1] is the MSB; for the 2-input case, vec[1]=x and vec[0]=y.
- s  in  1  FUT output.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- table_out  out  N_ROWS  observed truth table; bit i is s sampled for vector i.
- match  out  1  table_out == latched expected.
- err_count  out  N_IN+1  number of mismatching rows (0..N_ROWS).
- first_err_idx  out  N_IN  lowest mismatching row index; 0 when err_count==0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State → IDLE.
  - All outputs → 0: vec, busy, done, table_out, match, err_count, first_err_idx.
  - Latched expected → 0; settle counter → 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - vec=0 and busy=0; result outputs hold the last sweep's values.
  - On an edge with start=1:
    - Latch expected.
    - Clear table_out, err_count, first_err_idx and match.
    - Set vec=0, settle counter=SETTLE-1, busy=1; go to RUN.
- RUN, on each edge:
  - If the settle counter is nonzero, decrement it; vec holds.
  - If the counter is zero (sample edge):
    - table_out[vec] <= s.
    - If s != expected_q[vec]: err_count++. If this is the first mismatch, also first_err_idx <= vec.
    - If vec == N_ROWS-1: go to DONE, busy <= 0, done <= 1, vec <= 0, match <= (no mismatches including this row).
    - Otherwise: vec++ and reload the counter with SETTLE-1.
- DONE:
  - done is high for exactly one cycle; next edge → IDLE with done=0.
  - start is ignored in DONE.
  - A start asserted on the cycle after done is accepted.
- Timing:
  - Each vector is held for exactly SETTLE cycles.
  - s is sampled on the last edge of that hold window, so the FUT sees a stable vec for ≥1 full cycle.
  - Start accepted at edge E0 → samples at edges E0+k*SETTLE for k=1..N_ROWS.
  - done is high in the cycle after edge E0+N_ROWS*SETTLE.
  - busy is high from E0 until that final sample edge.
- start while busy (RUN): ignored, with no restart and no effect.
- Reset mid-sweep: sweep aborted, all outputs zero, partial results discarded.
- Changes to expected after start have no effect; only the latched copy is used.
- Width rule: err_count is N_IN+1 bits so that N_ROWS mismatches does not wrap.
- Results (table_out, match, err_count, first_err_idx) are valid from the done cycle until the next accepted start.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, RUN, DONE}.
  - Helper constant/function for N_ROWS = 1<<N_IN.
  - Width function for err_count.
- One natural sub-module: tt_settle_timer.
  - Loadable down-counter with reload value SETTLE-1.
  - Outputs a `zero` flag.
  - Keeps the main FSM free of timing arithmetic.

Test Plan:
- Nominal: N_IN=2, SETTLE=1, FUT s=~x&y, expected=4'b0010, start pulse.
  - Required: vec goes 0,1,2,3 on consecutive cycles; table_out=4'b0010, match=1, err_count=0, first_err_idx=0.
  - done is high exactly 5 cycles after the start edge, for 1 cycle.
- Mismatch: same FUT, expected=4'b1000 (AND).
  - Required: table_out=4'b0010, match=0, err_count=2, first_err_idx=1.
- Settle timing: SETTLE=3, FUT s=x^y, expected=4'b0110.
  - Required: each vec value held 3 cycles; done 13 cycles after start; match=1.
- Start while busy: re-pulse start at cycles 2 and 3 of the nominal sweep.
  - Required: identical result and timing to nominal; no restart.
- Reset mid-sweep: drop rst_n asynchronously while vec=2.
  - Required: all outputs 0 immediately without waiting for a clock edge.
  - After release, a fresh start completes normally.
- Wide/back-to-back: N_IN=3, FUT constant 1, expected=8'hFF.
  - Required: match=1, err_count=0.
  - Start on the cycle after done with expected=8'h00: err_count=8 (4'b1000, no wrap), first_err_idx=0.
